// File: rtl/avg_frame_ctrl_pkg.sv
// Shared definitions for the pair-averaging frame controller: state encoding,
// default geometry and the number of results produced per frame.
package avg_pkg;

  // Frame controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } avg_state_e;

  // Default sample/result width, frame depth and pair distance
  localparam int AVG_W     = 8;
  localparam int AVG_DEPTH = 128;
  localparam int AVG_LAG   = 8;

  // Pairs (i, i+LAG) that fit inside one frame
  localparam int AVG_RESULTS = AVG_DEPTH - AVG_LAG;

endpackage : avg_pkg

// File: rtl/avg_frame_ctrl_if.sv
// Handshake bundle of the frame controller: arm/status, sample input stream
// and averaged result stream. The controller uses the slave side, the sample
// source / result consumer uses the master side.
interface avg_frame_ctrl_if
  import avg_pkg::*;
#(
  parameter int W     = AVG_W,
  parameter int DEPTH = AVG_DEPTH
);

  logic                     start;
  logic                     in_valid;
  logic [W-1:0]             in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [W-1:0]             out_data;
  logic [$clog2(DEPTH)-1:0] out_index;
  logic                     out_ready;
  logic                     busy;
  logic                     done;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, busy, done
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, busy, done
  );

endinterface : avg_frame_ctrl_if

// File: rtl/avg_frame_ctrl_pair_round.sv
// Combinational W-bit rounding averager: avg = (a + b) / 2 rounded half up.
// The sum is formed one bit wider so the carry never gets lost; the shifted
// sum plus the dropped LSB can never exceed the W-bit maximum.
module avg_pair_round
  import avg_pkg::*;
#(
  parameter int W = AVG_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_avg
);

  logic [W:0] w_sum;

  // Widened sum, then halve and round on the dropped bit
  always_comb begin
    w_sum = {1'b0, i_a} + {1'b0, i_b};
    o_avg = w_sum[W:1] + {{(W-1){1'b0}}, w_sum[0]};
  end

endmodule : avg_pair_round

// File: rtl/avg_frame_ctrl.sv
// Frame controller for the pair-averaging datapath.
// Arms on start, loads DEPTH samples over a valid/ready handshake, then emits
// DEPTH-LAG rounded averages of (buf[i], buf[i+LAG]) and pulses done.
// Build option: define AVG_BACKPRESSURE_EN to honour out_ready; without it the
// result stream runs back-to-back and out_ready is treated as 1.
module avg_frame_ctrl
  import avg_pkg::*;
#(
  parameter int W     = AVG_W,
  parameter int DEPTH = AVG_DEPTH,
  parameter int LAG   = AVG_LAG
) (
  input  logic              clk,
  input  logic              reset,
  avg_frame_ctrl_if.slave   bus
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             RESULTS  = DEPTH - LAG;
  localparam logic [AW-1:0]  LAST_WR  = AW'(DEPTH - 1);
  localparam logic [AW-1:0]  LAST_IDX = AW'(RESULTS - 1);

  avg_state_e    r_state;
  avg_state_e    w_next_state;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;   // next pair to be loaded into the result register
  logic [W-1:0]  r_mem [DEPTH];

  logic          r_in_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [AW-1:0] r_out_index;

  logic          w_in_ready_nx;
  logic          w_busy_nx;
  logic          w_done_nx;

  logic          w_out_ready;
  logic          w_wr_en;
  logic          w_last_wr;
  logic          w_accept;
  logic          w_last_beat;
  logic          w_load_res;
  logic [AW-1:0] w_addr_b;
  logic [W-1:0]  w_sample_a;
  logic [W-1:0]  w_sample_b;
  logic [W-1:0]  w_avg;

`ifdef AVG_BACKPRESSURE_EN
  assign w_out_ready = bus.out_ready;
`else
  // Consumer is assumed always ready; the port stays referenced but has no effect
  assign w_out_ready = bus.out_ready | 1'b1;
`endif

  assign w_wr_en     = (r_state == ST_LOAD) && bus.in_valid && r_in_ready;
  assign w_last_wr   = w_wr_en && (r_wr_ptr == LAST_WR);
  assign w_accept    = r_out_valid && w_out_ready;
  assign w_last_beat = w_accept && (r_out_index == LAST_IDX);
  // Load a result when the register is empty or being drained, except after the last pair
  assign w_load_res  = (r_state == ST_RUN) && (!r_out_valid || w_accept) && !w_last_beat;
  assign w_addr_b    = r_rd_ptr + AW'(LAG);

  // Sample buffer read ports for the pair (rd_ptr, rd_ptr+LAG)
  always_comb begin
    w_sample_a = r_mem[r_rd_ptr];
    w_sample_b = r_mem[w_addr_b];
  end

  avg_pair_round #(
    .W (W)
  ) u_pair_round (
    .i_a   (w_sample_a),
    .i_b   (w_sample_b),
    .o_avg (w_avg)
  );

  // Sample buffer write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next_state = ST_LOAD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (w_last_wr) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (w_last_beat) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the next state so they register with it
  always_comb begin
    w_in_ready_nx = 1'b0;
    w_busy_nx     = 1'b0;
    w_done_nx     = 1'b0;
    case (w_next_state)
      ST_IDLE: begin
        w_in_ready_nx = 1'b0;
        w_busy_nx     = 1'b0;
        w_done_nx     = 1'b0;
      end
      ST_LOAD: begin
        w_in_ready_nx = 1'b1;
        w_busy_nx     = 1'b1;
        w_done_nx     = 1'b0;
      end
      ST_RUN: begin
        w_in_ready_nx = 1'b0;
        w_busy_nx     = 1'b1;
        w_done_nx     = 1'b0;
      end
      ST_DONE: begin
        w_in_ready_nx = 1'b0;
        w_busy_nx     = 1'b1;
        w_done_nx     = 1'b1;
      end
      default: begin
        w_in_ready_nx = 1'b0;
        w_busy_nx     = 1'b0;
        w_done_nx     = 1'b0;
      end
    endcase
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_in_ready <= w_in_ready_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
    end
  end

  // Write pointer: cleared on arm, advanced per accepted sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
    end else if ((r_state == ST_IDLE) && bus.start) begin
      r_wr_ptr <= '0;
    end else if (w_wr_en) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
    end
  end

  // Read pointer: cleared when the frame is complete, advanced per loaded result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
    end else if (w_last_wr) begin
      r_rd_ptr <= '0;
    end else if (w_load_res) begin
      r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Result register; holds stable while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
    end else if (w_load_res) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_avg;
      r_out_index <= r_rd_ptr;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_index = r_out_index;

endmodule : avg_frame_ctrl
